// File: rtl/uart_rx_frame.sv
// UART receive front-end: 2-FF pin synchroniser, 3-sample majority oversampling, 8N1 framing, byte hold with ack/overrun.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 UART_rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] S_LO  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S_MID = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S_HI  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_TOP = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_TOP = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t               state, state_n;
    logic                 sync1, rxs;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic                 commit_pend;
    logic                 decide, vote;
    logic                 do_shift, good_stop, bad_frame;
`ifdef UART_RX_PARITY_EN
    logic                 par_err;
`endif

    assign decide = baud_tick && (cnt == S_HI);
    assign vote   = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        do_shift  = 1'b0;
        good_stop = 1'b0;
        bad_frame = 1'b0;
        case (state)
            IDLE:  if (baud_tick && !rxs) state_n = START;
            START: if (decide) state_n = vote ? IDLE : DATA;
            DATA: begin
                if (decide) begin
                    do_shift = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == B_TOP) state_n = PARITY;
`else
                    if (bit_cnt == B_TOP) state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (decide) state_n = STOP;
`endif
            STOP: begin
                if (decide) begin
                    // a bad parity bit still consumes the stop bit; only a low stop bit leads to BREAK
`ifdef UART_RX_PARITY_EN
                    good_stop = vote && !par_err;
                    bad_frame = !vote || par_err;
`else
                    good_stop = vote;
                    bad_frame = !vote;
`endif
                    state_n = vote ? IDLE : BREAK;
                end
            end
            BREAK: if (baud_tick && rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1       <= 1'b1;
            rxs         <= 1'b1;
            cnt         <= '0;
            bit_cnt     <= '0;
            smp         <= '0;
            shreg       <= '0;
            commit_pend <= 1'b0;
            frame_err   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err     <= 1'b0;
`endif
        end else begin
            sync1 <= UART_rxd;
            rxs   <= sync1;

            if (baud_tick) begin
                if (state == IDLE || state == BREAK)
                    cnt <= (state_n == START) ? CW'(1) : '0;
                else if (state_n == IDLE || state_n == BREAK)
                    cnt <= '0;
                else
                    cnt <= (cnt == C_TOP) ? '0 : cnt + 1'b1;
                if (cnt == S_LO)  smp[0] <= rxs;
                if (cnt == S_MID) smp[1] <= rxs;
            end

            if (state == START && decide) bit_cnt <= '0;
            else if (do_shift)            bit_cnt <= bit_cnt + 1'b1;

            // first received bit ends up in bit 0 after DATA_BITS shifts
            if (do_shift) shreg <= DATA_BITS'({vote, shreg} >> 1);

`ifdef UART_RX_PARITY_EN
            if (state == PARITY && decide) par_err <= (^shreg) ^ vote;
`endif

            commit_pend <= good_stop;
            frame_err   <= bad_frame;

            if (commit_pend) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                    overrun  <= 1'b0;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: frame-level event model plus directed literal checks and random frames.
module tb_uart_rx_frame;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NB = DB + 1;
`else
    localparam int NB = DB;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          baud_tick = 1'b0;
    logic          UART_rxd = 1'b1;
    logic          rx_ack = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, overrun, busy;

    uart_rx_frame #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .UART_rxd(UART_rxd),
        .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // edge-sampled copies of the inputs, read by the model at the following negedge
    int unsigned tick_no = 0;
    logic ack_e = 1'b0, tick_e = 1'b0, rst_e = 1'b0;
    always @(posedge clk) begin
        ack_e  <= rx_ack;
        tick_e <= baud_tick;
        rst_e  <= !reset;
        if (baud_tick) tick_no <= tick_no + 1;
    end

    initial begin
        int unsigned k = 0;
        forever begin
            @(negedge clk);
            k++;
            baud_tick = (k % 4 == 0);
        end
    end

    logic man_ack = 1'b0;
    bit   rand_ack = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            rx_ack = man_ack | (rand_ack && ($urandom_range(0, 99) < 3));
        end
    end

    // model: each frame is an event at the tick where its stop bit is decided
    typedef struct {
        int unsigned   tick;
        bit            good;
        logic [DB-1:0] data;
    } ev_t;
    ev_t           evq[$];
    logic [DB-1:0] m_data = '0;
    logic [DB-1:0] pend_byte = '0;
    bit            m_valid = 0, m_ovr = 0, m_ferr = 0, pend = 0;

    initial begin
        bit            commit;
        logic [DB-1:0] cbyte;
        ev_t           ev;
        forever begin
            @(negedge clk);
            commit = pend;
            cbyte  = pend_byte;
            pend   = 0;
            m_ferr = 0;
            if (rst_e) begin
                m_data  = '0;
                m_valid = 0;
                m_ovr   = 0;
                evq.delete();
            end else begin
                if (commit) begin
                    if (m_valid && !ack_e) m_ovr = 1;
                    else begin
                        m_data  = cbyte;
                        m_valid = 1;
                        m_ovr   = 0;
                    end
                end else if (ack_e && m_valid) begin
                    m_valid = 0;
                    m_ovr   = 0;
                end
                if (tick_e && evq.size() > 0 && evq[0].tick == tick_no) begin
                    ev = evq.pop_front();
                    if (ev.good) begin
                        pend      = 1;
                        pend_byte = ev.data;
                    end else begin
                        m_ferr = 1;
                    end
                end
            end
            chk("rx_valid", 32'(rx_valid), 32'(m_valid));
            chk("rx_data", 32'(rx_data), 32'(m_data));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
    endtask

    task automatic drive_bits(input logic v, input int n);
        UART_rxd = v;
        repeat (n) wait_tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive_bits(1'b1, n);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // the line value set after tick edge t is seen by the receiver at tick t+1;
    // start seen at t0+1, each decision at sample count 9, so stop decision = t0+10+16*(NB+1)
    task automatic send(input logic [DB-1:0] b, input bit stop_ok, input bit par_flip, input bit ack_at_commit);
        int unsigned t0;
        ev_t ev;
        wait_tick();
        @(negedge clk);
        t0 = tick_no;
        ev.tick = t0 + 10 + 16 * (NB + 1);
        ev.data = b;
`ifdef UART_RX_PARITY_EN
        ev.good = stop_ok && !par_flip;
`else
        ev.good = stop_ok;
`endif
        evq.push_back(ev);
        drive_bits(1'b0, OS);
        for (int i = 0; i < DB; i++) drive_bits(b[i], OS);
`ifdef UART_RX_PARITY_EN
        drive_bits((^b) ^ par_flip, OS);
`endif
        if (ack_at_commit) begin
            UART_rxd = stop_ok;
            repeat (10) wait_tick();
            @(negedge clk);
            man_ack = 1'b1;
            @(negedge clk);
            man_ack = 1'b0;
            repeat (6) wait_tick();
            @(negedge clk);
        end else begin
            drive_bits(stop_ok, OS);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        reset = 1'b1;
        idle(4);

        // clean frame
        send(8'hA5, 1, 0, 0);
        idle(4);
        chk("a5_data", 32'(rx_data), 32'h A5);
        chk("a5_valid", 32'(rx_valid), 32'd1);
        chk("a5_busy", 32'(busy), 32'd0);
        pulse_ack();
        chk("a5_ack_valid", 32'(rx_valid), 32'd0);

        // short low glitch on an idle line
        wait_tick();
        @(negedge clk);
        drive_bits(1'b0, 3);
        idle(20);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_valid", 32'(rx_valid), 32'd0);

        // bad stop bit, line kept low
        send(8'h3C, 0, 0, 0);
        drive_bits(1'b0, 40);
        chk("break_busy", 32'(busy), 32'd1);
        idle(20);
        chk("break_idle_busy", 32'(busy), 32'd0);
        chk("break_valid", 32'(rx_valid), 32'd0);

        // overrun, then ack
        send(8'h11, 1, 0, 0);
        idle(4);
        send(8'h22, 1, 0, 0);
        idle(4);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_flag", 32'(overrun), 32'd1);
        pulse_ack();
        chk("ovr_ack_valid", 32'(rx_valid), 32'd0);
        chk("ovr_ack_flag", 32'(overrun), 32'd0);

        // ack coincident with second commit
        send(8'h11, 1, 0, 0);
        idle(4);
        send(8'h22, 1, 0, 1);
        idle(4);
        chk("coin_data", 32'(rx_data), 32'h22);
        chk("coin_valid", 32'(rx_valid), 32'd1);
        chk("coin_ovr", 32'(overrun), 32'd0);

        // reset in the middle of 0xFF (0x22 still held unacked)
        fork
            send(8'hFF, 1, 0, 0);
            begin
                repeat (1 + 16 * 5 + 8) wait_tick();
                @(negedge clk);
                chk("pre_rst_busy", 32'(busy), 32'd1);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                chk("rst_data", 32'(rx_data), 32'd0);
                chk("rst_valid", 32'(rx_valid), 32'd0);
                chk("rst_ferr", 32'(frame_err), 32'd0);
                chk("rst_ovr", 32'(overrun), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
            end
        join
        idle(4);
        send(8'h5A, 1, 0, 0);
        idle(4);
        chk("post_rst_data", 32'(rx_data), 32'h5A);
        chk("post_rst_valid", 32'(rx_valid), 32'd1);
        pulse_ack();

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1, 0, 0);
        idle(4);
        chk("par_ok_data", 32'(rx_data), 32'h07);
        chk("par_ok_valid", 32'(rx_valid), 32'd1);
        pulse_ack();
        send(8'h07, 1, 1, 0);
        idle(4);
        chk("par_bad_valid", 32'(rx_valid), 32'd0);
`endif

        // random frames with random acks and occasional bad stop bits
        rand_ack = 1'b1;
        repeat (25) begin
            logic [DB-1:0] b;
            bit sok, pfl;
            b   = DB'($urandom);
            sok = ($urandom_range(0, 99) >= 15);
            pfl = ($urandom_range(0, 99) < 10);
            send(b, sok, pfl, 0);
            idle(int'($urandom_range(2, 20)));
        end
        rand_ack = 1'b0;
        idle(10);
        chk("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
